// File: rtl/bot_distributor_if.sv
// Bundles the bot_distributor upstream handshake, the per-pipe fullness inputs
// and the broadcast/write outputs into one interface.
// slave: the distributor side; master: the bot source plus pipe side.
interface bot_distributor_if #(
    parameter int NUM_PIPES        = 4,
    parameter int EXTRA_DATA_WIDTH = 12
);
    logic                          inValid;
    logic                          inReady;
    logic [127:0]                  inBot;
    logic [5:0]                    inValidPermutes;
    logic [EXTRA_DATA_WIDTH-1:0]   inExtraData;
    logic [5*NUM_PIPES-1:0]        fifoFullness;
    logic [NUM_PIPES-1:0]          outWrite;
    logic [127:0]                  outBot;
    logic [5:0]                    outValidPermutes;
    logic [EXTRA_DATA_WIDTH-1:0]   outExtraData;
    logic [31:0]                   botsDistributed;
    logic [31:0]                   stallCycles;

    modport slave (
        input  inValid, inBot, inValidPermutes, inExtraData, fifoFullness,
        output inReady, outWrite, outBot, outValidPermutes, outExtraData,
               botsDistributed, stallCycles
    );

    modport master (
        output inValid, inBot, inValidPermutes, inExtraData, fifoFullness,
        input  inReady, outWrite, outBot, outValidPermutes, outExtraData,
               botsDistributed, stallCycles
    );
endinterface

// File: rtl/bot_distributor.sv
// Spreads one bot stream over NUM_PIPES input modules, picking the least-recently
// granted pipe whose fullness plus in-flight writes is below ALMOST_FULL.
// Latency: one cycle from accept to outWrite pulse. Backpressure: inReady drops
// when no pipe is eligible; it never depends on inValid.
// Ports: clk, rst (async active-low), bus (slave modport: inValid/inReady/inBot/
// inValidPermutes/inExtraData/fifoFullness in; outWrite/out* broadcast/counters out).
module bot_distributor #(
    parameter int NUM_PIPES        = 4,
    parameter int EXTRA_DATA_WIDTH = 12,
    parameter int ALMOST_FULL      = 20,
    parameter int FULLNESS_LAG     = 3
) (
    input logic            clk,
    input logic            rst,
    bot_distributor_if.slave bus
);
    localparam int PW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    logic [FULLNESS_LAG-1:0]     hist_q [NUM_PIPES];
    logic [7:0]                  eff [NUM_PIPES];
    logic [NUM_PIPES-1:0]        eligible;
    logic [PW-1:0]               ptr_q;
    logic [PW-1:0]               grant;
    logic [PW-1:0]               idx;
    logic                        found;
    logic                        in_ready;
    logic                        accept;
    logic                        wr_en;
    logic [NUM_PIPES-1:0]        wr_next;
    logic [NUM_PIPES-1:0]        out_write_q;
    logic [127:0]                bot_q;
    logic [5:0]                  perm_q;
    logic [EXTRA_DATA_WIDTH-1:0] extra_q;
    logic [31:0]                 dist_cnt_q;
    logic [31:0]                 stall_cnt_q;

    // Effective fullness counts writes already issued but not yet visible in
    // fifoFullness. The history captures a write in the same edge that raises
    // outWrite, so the pipe is covered during all FULLNESS_LAG feedback cycles.
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            eff[i] = 8'(bus.fifoFullness[5*i +: 5]);
            for (int b = 0; b < FULLNESS_LAG; b++) begin
                eff[i] = eff[i] + 8'(hist_q[i][b]);
            end
            eligible[i] = (eff[i] < 8'(ALMOST_FULL));
        end
    end

    // Round-robin search: first eligible pipe at or above the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_PIPES);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign in_ready = |eligible;
    assign accept   = bus.inValid & in_ready;
    // A bot with no valid permutation is consumed but written nowhere.
    assign wr_en    = accept & found & (|bus.inValidPermutes);
    assign wr_next  = wr_en ? (NUM_PIPES'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_write_q <= '0;
            bot_q       <= '0;
            perm_q      <= '0;
            extra_q     <= '0;
            ptr_q       <= '0;
            dist_cnt_q  <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            out_write_q <= wr_next;
            for (int i = 0; i < NUM_PIPES; i++) begin
                hist_q[i] <= (hist_q[i] << 1) | FULLNESS_LAG'(wr_next[i]);
            end
            if (accept) begin
                bot_q   <= bus.inBot;
                perm_q  <= bus.inValidPermutes;
                extra_q <= bus.inExtraData;
            end
            if (wr_en) begin
                ptr_q      <= (grant == PW'(NUM_PIPES - 1)) ? '0 : grant + PW'(1);
                dist_cnt_q <= dist_cnt_q + 32'd1;
            end
            if (bus.inValid && !in_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.inReady          = in_ready;
    assign bus.outWrite         = out_write_q;
    assign bus.outBot           = bot_q;
    assign bus.outValidPermutes = perm_q;
    assign bus.outExtraData     = extra_q;
    assign bus.botsDistributed  = dist_cnt_q;
    assign bus.stallCycles      = stall_cnt_q;
endmodule

// File: tb/tb_bot_distributor.sv
// Self-checking bench for bot_distributor: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_bot_distributor;
    localparam int NP  = 4;
    localparam int EW  = 12;
    localparam int AF  = 20;
    localparam int LAG = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bot_distributor_if #(.NUM_PIPES(NP), .EXTRA_DATA_WIDTH(EW)) bus ();

    bot_distributor #(
        .NUM_PIPES(NP), .EXTRA_DATA_WIDTH(EW), .ALMOST_FULL(AF), .FULLNESS_LAG(LAG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int              m_ptr;
    logic [31:0]     m_cnt;
    logic [31:0]     m_stall;
    logic [NP-1:0]   exp_wr;
    logic [NP-1:0]   m_wr_next;
    logic [127:0]    exp_bot;
    logic [5:0]      exp_perm;
    logic [EW-1:0]   exp_extra;
    int              cyc;
    int              acc_cyc_q[$];
    int              acc_pipe_q[$];
    logic [4:0]      full [NP];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_cnt     = '0;
        m_stall   = '0;
        exp_wr    = '0;
        m_wr_next = '0;
        exp_bot   = '0;
        exp_perm  = '0;
        exp_extra = '0;
        acc_cyc_q.delete();
        acc_pipe_q.delete();
    endtask

    // Writes to pipe p accepted in the last LAG cycles: issued, not yet visible in fullness.
    function automatic int outstanding(input int p);
        int n = 0;
        for (int j = 0; j < acc_cyc_q.size(); j++) begin
            if (acc_pipe_q[j] == p && acc_cyc_q[j] >= cyc - LAG && acc_cyc_q[j] < cyc) n++;
        end
        return n;
    endfunction

    // One clock: drive fullness, check outputs at the falling edge, advance model.
    task automatic cycle();
        bit el [NP];
        bit m_ready;
        int g;
        for (int i = 0; i < NP; i++) bus.fifoFullness[5*i +: 5] = full[i];
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < NP; i++) begin
            el[i] = (int'(full[i]) + outstanding(i)) < AF;
            if (el[i]) m_ready = 1'b1;
        end
        chk("in_ready", bus.inReady, m_ready);
        chk("out_write", bus.outWrite, exp_wr);
        chk("out_bot", bus.outBot, exp_bot);
        chk("out_perm", bus.outValidPermutes, exp_perm);
        chk("out_extra", bus.outExtraData, exp_extra);
        chk("bots_distributed", bus.botsDistributed, m_cnt);
        chk("stall_cycles", bus.stallCycles, m_stall);
        m_wr_next = '0;
        if (bus.inValid && m_ready) begin
            exp_bot   = bus.inBot;
            exp_perm  = bus.inValidPermutes;
            exp_extra = bus.inExtraData;
            if (bus.inValidPermutes != 6'd0) begin
                g = -1;
                for (int k = 0; k < NP; k++) begin
                    if (g < 0 && el[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
                end
                m_wr_next[g] = 1'b1;
                acc_cyc_q.push_back(cyc);
                acc_pipe_q.push_back(g);
                m_ptr = (g + 1) % NP;
                m_cnt = m_cnt + 32'd1;
            end
        end else if (bus.inValid) begin
            m_stall = m_stall + 32'd1;
        end
        while (acc_cyc_q.size() > 0 && acc_cyc_q[0] < cyc - LAG) begin
            void'(acc_cyc_q.pop_front());
            void'(acc_pipe_q.pop_front());
        end
        @(posedge clk);
        #1;
        exp_wr = m_wr_next;
        cyc++;
    endtask

    task automatic rand_bot(input logic [5:0] perm);
        bus.inBot           = {$urandom, $urandom, $urandom, $urandom};
        bus.inValidPermutes = perm;
        bus.inExtraData     = EW'($urandom);
    endtask

    task automatic idle(input int n);
        bus.inValid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        logic [31:0] st0;
        logic [31:0] cn0;
        logic [NP-1:0] want;
        cyc = 0;
        model_reset();
        bus.inValid = 1'b0;
        bus.inBot = '0;
        bus.inValidPermutes = '0;
        bus.inExtraData = '0;
        for (int i = 0; i < NP; i++) full[i] = 5'd0;
        for (int i = 0; i < NP; i++) bus.fifoFullness[5*i +: 5] = full[i];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_write", bus.outWrite, 0);
        chk("reset_out_bot", bus.outBot, 0);
        chk("reset_bots_distributed", bus.botsDistributed, 0);
        chk("reset_stall_cycles", bus.stallCycles, 0);
        rst = 1'b1;

        // 8 back-to-back bots into empty pipes: pure round-robin
        for (int k = 0; k < 8; k++) begin
            bus.inValid = 1'b1;
            rand_bot(6'b111111);
            cycle();
            want = NP'(1) << (k % NP);
            chk("rr_sequence", bus.outWrite, want);
        end
        bus.inValid = 1'b0;
        chk("rr_count", bus.botsDistributed, 8);

        // Zero-permute bot sandwiched between two valid bots
        cn0 = m_cnt;
        bus.inValid = 1'b1;
        rand_bot(6'b111111); cycle(); chk("zp_first", bus.outWrite, 4'b0001);
        rand_bot(6'b000000); cycle(); chk("zp_none", bus.outWrite, 4'b0000);
        rand_bot(6'b101010); cycle(); chk("zp_second", bus.outWrite, 4'b0010);
        bus.inValid = 1'b0;
        chk("zp_count", bus.botsDistributed - cn0, 2);
        idle(LAG + 1);

        // Pipe0 one below threshold, others full: one write, then LAG stall cycles
        full[0] = 5'd19; full[1] = 5'd25; full[2] = 5'd25; full[3] = 5'd25;
        st0 = m_stall; cn0 = m_cnt;
        bus.inValid = 1'b1;
        rand_bot(6'b111111);
        cycle();
        chk("af_first_write", bus.outWrite, 4'b0001);
        repeat (LAG) cycle();
        bus.inValid = 1'b0;
        chk("af_stall", bus.stallCycles - st0, LAG);
        chk("af_count", bus.botsDistributed - cn0, 1);
        chk("af_no_write", bus.outWrite, 4'b0000);
        idle(LAG + 1);

        // Everything at threshold for 10 cycles, then pipe2 drains
        for (int i = 0; i < NP; i++) full[i] = 5'd20;
        st0 = m_stall; cn0 = m_cnt;
        bus.inValid = 1'b1;
        rand_bot(6'b000111);
        repeat (10) cycle();
        chk("full_stall", bus.stallCycles - st0, 10);
        chk("full_count", bus.botsDistributed - cn0, 0);
        full[2] = 5'd5;
        cycle();
        chk("drain_pipe2", bus.outWrite, 4'b0100);
        bus.inValid = 1'b0;
        idle(LAG + 1);

        // Random traffic around the threshold
        for (int i = 0; i < NP; i++) full[i] = 5'($urandom_range(12, 22));
        for (int n = 0; n < 400; n++) begin
            bus.inValid = ($urandom_range(0, 3) != 0);
            rand_bot(($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
            if ($urandom_range(0, 3) == 0) full[$urandom_range(0, NP-1)] = 5'($urandom_range(0, 24));
            cycle();
        end
        bus.inValid = 1'b0;
        idle(LAG + 1);

        // Asynchronous reset while pipe1 is being written
        for (int i = 0; i < NP; i++) full[i] = 5'd0;
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        bus.inValid = 1'b1;
        rand_bot(6'b111111); cycle(); chk("pre_rst_wr0", bus.outWrite, 4'b0001);
        rand_bot(6'b111111); cycle(); chk("pre_rst_wr1", bus.outWrite, 4'b0010);
        bus.inValid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_out_write", bus.outWrite, 4'b0000);
        chk("async_rst_count", bus.botsDistributed, 0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b1;
        bus.inValid = 1'b1;
        rand_bot(6'b010101);
        cycle();
        chk("post_rst_pipe0", bus.outWrite, 4'b0001);
        bus.inValid = 1'b0;
        cycle();
        chk("post_rst_count", bus.botsDistributed, 1);

        // Short random tail after reset
        for (int n = 0; n < 50; n++) begin
            bus.inValid = ($urandom_range(0, 1) != 0);
            rand_bot(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 2) == 0) full[$urandom_range(0, NP-1)] = 5'($urandom_range(10, 24));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
